// File: rtl/prbs_train_pkg.sv
// Shared types and constants for the PRBS7 training controller and its word predictor.
package prbs_train_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        SYNC  = 3'd2,
        CHECK = 3'd3,
        DONE  = 3'd4
    } train_state_e;

    // PRBS7 polynomial x^7 + x^6 + 1
    localparam int unsigned PRBS_ORDER = 7;
    localparam int unsigned PRBS_TAP_A = 7;
    localparam int unsigned PRBS_TAP_B = 6;

    // Generator clear reloads every register bit with this value
    localparam logic PRBS_SEED_BIT = 1'b1;

endpackage

// File: rtl/prbs_train_if.sv
// Control and datapath signals between the alignment FSM, the PRBS datapath and the training controller.
interface prbs_train_if #(
    parameter int unsigned NBITS = 8,
    parameter int unsigned ERR_W = 16
) ();

    logic             start_i;
    logic             abort_i;
    logic             rx_valid_i;
    logic [NBITS-1:0] rx_data_i;
    logic             prbs_en_o;
    logic             prbs_clear_o;
    logic             busy_o;
    logic             done_o;
    logic             pass_o;
    logic             sync_fail_o;
    logic [ERR_W-1:0] err_cnt_o;

    modport master (
        output start_i, abort_i, rx_valid_i, rx_data_i,
        input  prbs_en_o, prbs_clear_o, busy_o, done_o, pass_o, sync_fail_o, err_cnt_o
    );

    modport slave (
        input  start_i, abort_i, rx_valid_i, rx_data_i,
        output prbs_en_o, prbs_clear_o, busy_o, done_o, pass_o, sync_fail_o, err_cnt_o
    );

endinterface

// File: rtl/prbs7_word_predict.sv
// Purely combinational PRBS7 next-word predictor: given the previous NBITS-wide word,
// returns the word the generator emits next (oldest bit in the MSB).
module prbs7_word_predict
    import prbs_train_pkg::*;
#(
    parameter int unsigned NBITS = 8
) (
    input  logic [NBITS-1:0] prev_i,
    output logic [NBITS-1:0] pred_c_o
);

    localparam int unsigned SW = NBITS + PRBS_ORDER;

    // Seed the top of the shift history with the newest 7 bits, then extend it downward
    function automatic logic [NBITS-1:0] predict(input logic [NBITS-1:0] p);
        logic [SW-1:0] s;
        s = '0;
        s[SW-1:NBITS] = p[PRBS_ORDER-1:0];
        for (int i = NBITS - 1; i >= 0; i--) begin
            s[i] = s[i+PRBS_TAP_A] ^ s[i+PRBS_TAP_B];
        end
        return s[NBITS-1:0];
    endfunction

    always_comb begin
        pred_c_o = predict(prev_i);
    end

endmodule

// File: rtl/prbs_train_ctrl.sv
// PRBS7 RX training sequencer: clears/enables the generator, self-synchronises to the
// returned stream, counts word errors over a fixed window and reports pass/fail.
module prbs_train_ctrl
    import prbs_train_pkg::*;
#(
    parameter int unsigned NBITS        = 8,
    parameter int unsigned SYNC_WORDS   = 4,
    parameter int unsigned SYNC_TIMEOUT = 1024,
    parameter int unsigned CHECK_LEN    = 4096,
    parameter int unsigned ERR_THR      = 0,
    parameter int unsigned ERR_W        = 16
) (
    input  logic         clk_i,
    input  logic         reset_i,
    prbs_train_if.slave  bus
);

    localparam int unsigned TMO_W  = $clog2(SYNC_TIMEOUT + 1);
    localparam int unsigned WCNT_W = $clog2(CHECK_LEN + 1);
    localparam int unsigned MCNT_W = 4;

    train_state_e      state_q, state_d;
    logic [NBITS-1:0]  prev_q, prev_d;
    logic              have_prev_q, have_prev_d;
    logic [MCNT_W-1:0] match_q, match_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic [ERR_W-1:0]  err_q, err_d;
    logic              pass_q, pass_d;
    logic              sfail_q, sfail_d;
    logic              done_q, done_d;
    logic              en_q, en_d;
    logic              clr_q, clr_d;
    logic [NBITS-1:0]  pred;
    logic              mismatch;

    prbs7_word_predict #(.NBITS(NBITS)) u_predict (
        .prev_i   (prev_q),
        .pred_c_o (pred)
    );

    assign mismatch = (bus.rx_data_i != pred);

    always_comb begin
        state_d     = state_q;
        prev_d      = prev_q;
        have_prev_d = have_prev_q;
        match_d     = match_q;
        tmo_d       = tmo_q;
        wcnt_d      = wcnt_q;
        err_d       = err_q;
        pass_d      = pass_q;
        sfail_d     = sfail_q;
        done_d      = 1'b0;

        unique case (state_q)
            IDLE, DONE: begin
                if (bus.start_i) begin
                    state_d = CLEAR;
                    err_d   = '0;
                    pass_d  = 1'b0;
                    sfail_d = 1'b0;
                end
            end
            CLEAR: begin
                state_d     = SYNC;
                have_prev_d = 1'b0;
                match_d     = '0;
                tmo_d       = '0;
                wcnt_d      = '0;
            end
            SYNC: begin
                // Timeout runs on every cycle, valid or not
                tmo_d = tmo_q + TMO_W'(1);
                if (bus.rx_valid_i) begin
                    prev_d      = bus.rx_data_i;
                    have_prev_d = 1'b1;
                    if (!have_prev_q || mismatch) begin
                        match_d = '0;
                    end else begin
                        match_d = match_q + MCNT_W'(1);
                    end
                end
                if (match_d == MCNT_W'(SYNC_WORDS)) begin
                    state_d = CHECK;
                end else if (tmo_d == TMO_W'(SYNC_TIMEOUT)) begin
                    state_d = DONE;
                    sfail_d = 1'b1;
                    pass_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            CHECK: begin
                if (bus.rx_valid_i) begin
                    prev_d = bus.rx_data_i;
                    wcnt_d = wcnt_q + WCNT_W'(1);
                    if (mismatch && (err_q != '1)) begin
                        err_d = err_q + ERR_W'(1);
                    end
                    if (wcnt_d == WCNT_W'(CHECK_LEN)) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        pass_d  = (err_d <= ERR_W'(ERR_THR));
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort wins over everything, including a simultaneous start
        if (bus.abort_i) begin
            state_d = IDLE;
            done_d  = 1'b0;
            pass_d  = 1'b0;
            err_d   = err_q;
            sfail_d = sfail_q;
        end

        en_d  = (state_d == CLEAR) || (state_d == SYNC) || (state_d == CHECK);
        clr_d = (state_d == CLEAR);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            prev_q      <= {NBITS{PRBS_SEED_BIT}};
            have_prev_q <= 1'b0;
            match_q     <= '0;
            tmo_q       <= '0;
            wcnt_q      <= '0;
            err_q       <= '0;
            pass_q      <= 1'b0;
            sfail_q     <= 1'b0;
            done_q      <= 1'b0;
            en_q        <= 1'b0;
            clr_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            prev_q      <= prev_d;
            have_prev_q <= have_prev_d;
            match_q     <= match_d;
            tmo_q       <= tmo_d;
            wcnt_q      <= wcnt_d;
            err_q       <= err_d;
            pass_q      <= pass_d;
            sfail_q     <= sfail_d;
            done_q      <= done_d;
            en_q        <= en_d;
            clr_q       <= clr_d;
        end
    end

    assign bus.prbs_en_o    = en_q;
    assign bus.prbs_clear_o = clr_q;
    assign bus.busy_o       = en_q;
    assign bus.done_o       = done_q;
    assign bus.pass_o       = pass_q;
    assign bus.sync_fail_o  = sfail_q;
    assign bus.err_cnt_o    = err_q;

endmodule

// File: tb/tb_prbs_train_ctrl.sv
// Directed bench for prbs_train_ctrl: two instances share stimulus (ERR_THR=0/ERR_W=16 and ERR_THR=2/ERR_W=4).
module tb_prbs_train_ctrl;

    logic clk_i = 1'b0;
    logic reset_i;
    always #5 clk_i = ~clk_i;

    prbs_train_if #(.NBITS(8), .ERR_W(16)) if_a ();
    prbs_train_if #(.NBITS(8), .ERR_W(4))  if_b ();

    assign if_b.start_i    = if_a.start_i;
    assign if_b.abort_i    = if_a.abort_i;
    assign if_b.rx_valid_i = if_a.rx_valid_i;
    assign if_b.rx_data_i  = if_a.rx_data_i;

    prbs_train_ctrl #(.NBITS(8), .SYNC_WORDS(4), .SYNC_TIMEOUT(32), .CHECK_LEN(16),
                      .ERR_THR(0), .ERR_W(16)) dut_a (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .bus     (if_a.slave)
    );

    prbs_train_ctrl #(.NBITS(8), .SYNC_WORDS(4), .SYNC_TIMEOUT(32), .CHECK_LEN(16),
                      .ERR_THR(2), .ERR_W(4)) dut_b (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .bus     (if_b.slave)
    );

    int tests = 0;
    int fails = 0;
    logic [7:0] prbs_w [0:31];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] d);
        if_a.rx_valid_i = v;
        if_a.rx_data_i  = d;
    endtask

    task automatic start_run();
        if_a.start_i = 1'b1;
        tick();
        if_a.start_i = 1'b0;
        tick();
    endtask

    // Feed the reference stream; optional single-word corruption, optional start pulse, optional gaps
    task automatic feed(input int n, input int flip_idx, input logic [7:0] mask,
                        input bit sparse, input int start_at, output int early);
        early = 0;
        for (int k = 0; k < n; k++) begin
            if_a.start_i = (k == start_at);
            drive(1'b1, (k == flip_idx) ? (prbs_w[k] ^ mask) : prbs_w[k]);
            tick();
            if_a.start_i = 1'b0;
            if (k == n - 1) break;
            if (if_a.done_o || if_b.done_o) early++;
            if (sparse) begin
                drive(1'b0, 8'h5A);
                tick();
                if (if_a.done_o || if_b.done_o) early++;
            end
        end
    endtask

    // Bit-serial PRBS7 reference: first word all ones, then b[n] = b[n-7] ^ b[n-6], MSB first
    task automatic gen_stream();
        bit s [0:255];
        for (int n = 0; n < 256; n++) begin
            s[n] = (n < 8) ? 1'b1 : (s[n-7] ^ s[n-6]);
        end
        for (int w = 0; w < 32; w++) begin
            for (int b = 0; b < 8; b++) prbs_w[w][7-b] = s[8*w+b];
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int early;
        int n;
        gen_stream();
        reset_i      = 1'b1;
        if_a.start_i = 1'b0;
        if_a.abort_i = 1'b0;
        drive(1'b0, 8'h00);
        tick();
        tick();
        chk("reset_outs_a", {if_a.prbs_en_o, if_a.prbs_clear_o, if_a.busy_o, if_a.done_o,
                             if_a.pass_o, if_a.sync_fail_o}, 32'h0);
        chk("reset_err_a", if_a.err_cnt_o, 32'h0);
        reset_i = 1'b0;
        tick();

        // Ideal loopback
        if_a.start_i = 1'b1;
        tick();
        if_a.start_i = 1'b0;
        chk("t1_clear_cycle", {if_a.prbs_clear_o, if_a.prbs_en_o, if_a.busy_o}, 32'h7);
        tick();
        chk("t1_sync_cycle", {if_a.prbs_clear_o, if_a.prbs_en_o}, 32'h1);
        feed(21, -1, 8'h00, 1'b0, -1, early);
        chk("t1_early_done", early, 0);
        chk("t1_done", if_a.done_o, 1);
        chk("t1_pass_err_a", {if_a.pass_o, if_a.err_cnt_o}, {16'h0, 1'b1, 16'h0});
        chk("t1_en_busy", {if_a.prbs_en_o, if_a.busy_o}, 32'h0);
        chk("t1_pass_b", if_b.pass_o, 1);
        drive(1'b0, 8'h00);
        tick();
        chk("t1_done_pulse", if_a.done_o, 0);
        chk("t1_pass_held", if_a.pass_o, 1);

        // Single bit flip in the window; start during CHECK must be ignored
        if_a.start_i = 1'b1;
        tick();
        if_a.start_i = 1'b0;
        chk("t2_pass_cleared", if_a.pass_o, 0);
        tick();
        feed(21, 10, 8'h10, 1'b0, 12, early);
        chk("t2_early_done", early, 0);
        chk("t2_done", if_a.done_o, 1);
        chk("t2_err_a", if_a.err_cnt_o, 2);
        chk("t2_pass_a", if_a.pass_o, 0);
        chk("t2_err_b", if_b.err_cnt_o, 2);
        chk("t2_pass_b", if_b.pass_o, 1);
        drive(1'b0, 8'h00);

        // Sparse valid, clean stream
        start_run();
        feed(21, -1, 8'h00, 1'b1, -1, early);
        chk("t3_early_done", early, 0);
        chk("t3_done", if_a.done_o, 1);
        chk("t3_pass_err_a", {if_a.pass_o, if_a.err_cnt_o}, {16'h0, 1'b1, 16'h0});
        chk("t3_pass_b", if_b.pass_o, 1);
        drive(1'b0, 8'h00);

        // Every CHECK word wrong: saturation on the 4-bit instance
        start_run();
        early = 0;
        for (int k = 0; k < 21; k++) begin
            drive(1'b1, (k < 5) ? prbs_w[k] : 8'hA5);
            tick();
            if (k < 20 && if_a.done_o) early++;
        end
        chk("t4_early_done", early, 0);
        chk("t4_done", if_a.done_o, 1);
        chk("t4_err_a", if_a.err_cnt_o, 16);
        chk("t4_err_b_sat", if_b.err_cnt_o, 15);
        chk("t4_pass", {if_a.pass_o, if_b.pass_o}, 0);
        drive(1'b0, 8'h00);

        // No signal: sync timeout 32 cycles after SYNC entry
        if_a.start_i = 1'b1;
        tick();
        if_a.start_i = 1'b0;
        drive(1'b1, 8'hA5);
        n = 0;
        while (!if_a.done_o && n < 100) begin
            tick();
            n++;
        end
        chk("t5_timeout_cycles", n, 33);
        chk("t5_sync_fail", if_a.sync_fail_o, 1);
        chk("t5_pass_en", {if_a.pass_o, if_a.prbs_en_o, if_a.busy_o}, 0);
        tick();
        chk("t5_after", {if_a.done_o, if_a.sync_fail_o, if_a.prbs_en_o}, 32'h2);
        drive(1'b0, 8'h00);

        // Abort mid-CHECK with simultaneous start
        start_run();
        feed(10, 7, 8'h01, 1'b0, -1, early);
        chk("t6_err_before_abort", if_a.err_cnt_o, 2);
        if_a.abort_i = 1'b1;
        if_a.start_i = 1'b1;
        drive(1'b1, prbs_w[10]);
        tick();
        if_a.abort_i = 1'b0;
        if_a.start_i = 1'b0;
        chk("t6_abort_outs", {if_a.prbs_en_o, if_a.busy_o, if_a.done_o, if_a.pass_o,
                              if_a.prbs_clear_o}, 0);
        chk("t6_abort_err_kept", if_a.err_cnt_o, 2);
        drive(1'b0, 8'h00);
        tick();
        chk("t6_idle", {if_a.prbs_en_o, if_a.done_o}, 0);
        if_a.start_i = 1'b1;
        tick();
        if_a.start_i = 1'b0;
        chk("t6_clear_pulse", {if_a.prbs_clear_o, if_a.err_cnt_o}, {15'h0, 1'b1, 16'h0});
        tick();
        chk("t6_clear_one_cycle", {if_a.prbs_clear_o, if_a.prbs_en_o}, 32'h1);
        feed(21, -1, 8'h00, 1'b0, -1, early);
        chk("t6_early_done", early, 0);
        chk("t6_rerun", {if_a.done_o, if_a.pass_o, if_a.err_cnt_o}, {14'h0, 2'b11, 16'h0});
        drive(1'b0, 8'h00);

        // Reset during CHECK
        start_run();
        feed(12, 7, 8'h01, 1'b0, -1, early);
        chk("t7_err_before_reset", if_a.err_cnt_o, 2);
        reset_i = 1'b1;
        tick();
        chk("t7_reset_outs", {if_a.prbs_en_o, if_a.prbs_clear_o, if_a.busy_o, if_a.done_o,
                              if_a.pass_o, if_a.sync_fail_o, if_a.err_cnt_o}, 32'h0);
        reset_i = 1'b0;
        drive(1'b0, 8'h00);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
